// File: rtl/timer_countdown.sv
// timer_countdown
//   Microwave cook timer. Assembles an M:SS time from BCD key digits
//   (left-shift entry, one digit per falling edge of loadn), then counts it
//   down once per rising edge of pgt_1Hz under start/stop/clear control.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   D, loadn       BCD key digit and its active-low strobe
//   pgt_1Hz        1 Hz time base
//   startn/stopn/clearn  active-low panel controls, level-sampled
//   mins/sec_tens/sec_ones  BCD display digits
//   zero, mag_on, done      registered status outputs
module timer_countdown #(
  parameter int SEC_TENS_RELOAD = 5,
  parameter int MAX_DIGIT       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] mins_q, mins_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       zero_q, zero_d;
  logic       mag_on_q, mag_on_d;
  logic       done_q, done_d;
  logic       loadn_q, loadn_d;
  logic       tick_q, tick_d;
  logic       load_ev, tick_ev;

  always_comb begin
    state_d    = state_q;
    mins_d     = mins_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    loadn_d    = loadn;
    tick_d     = pgt_1Hz;
    load_ev    = loadn_q & ~loadn;
    tick_ev    = pgt_1Hz & ~tick_q;

    if (!clearn) begin
      state_d    = S_IDLE;
      mins_d     = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A start request swallows any key strobe on the same cycle; the
          // start decision uses the digits already on display.
          if (!startn) begin
            if (!zero_q) state_d = S_RUN;
          end else if (load_ev && (D <= 4'(MAX_DIGIT))) begin
            mins_d     = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = D;
          end
        end
        S_RUN: begin
          if (!stopn) begin
            state_d = S_PAUSE;
          end else if (tick_ev) begin
            if (sec_ones_q != 4'd0) begin
              sec_ones_d = sec_ones_q - 4'd1;
            end else if (sec_tens_q != 4'd0) begin
              sec_tens_d = sec_tens_q - 4'd1;
              sec_ones_d = 4'd9;
            end else begin
              mins_d     = mins_q - 4'd1;
              sec_tens_d = 4'(SEC_TENS_RELOAD);
              sec_ones_d = 4'd9;
            end
            if ((mins_d == 4'd0) && (sec_tens_d == 4'd0) && (sec_ones_d == 4'd0))
              state_d = S_DONE;
          end
        end
        S_PAUSE: begin
          if (stopn && !startn) state_d = S_RUN;
        end
        default: ; // S_DONE: only clear leaves
      endcase
    end

    // Status flags are derived from next-state values so they line up with
    // the registered digits and state on every cycle.
    zero_d   = (mins_d == 4'd0) && (sec_tens_d == 4'd0) && (sec_ones_d == 4'd0);
    mag_on_d = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mins_q     <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      zero_q     <= 1'b1;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
      loadn_q    <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mins_q     <= mins_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      zero_q     <= zero_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
      loadn_q    <= loadn_d;
      tick_q     <= tick_d;
    end
  end

  assign mins     = mins_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign zero     = zero_q;
  assign mag_on   = mag_on_q;
  assign done     = done_q;

endmodule

// File: tb/tb_timer_countdown.sv
// tb_timer_countdown
//   Scoreboard bench for timer_countdown. The driver applies inputs on the
//   falling edge, advances a reference model (time kept as minutes plus a
//   0..99 seconds field) and queues the expected outputs; a monitor pops and
//   compares one entry just after each rising edge.
module tb_timer_countdown;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1, pgt_1Hz = 1'b0;
  logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       zero, mag_on, done;

  timer_countdown #(.SEC_TENS_RELOAD(5), .MAX_DIGIT(9)) dut (
    .clk(clk), .rst(rst), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .startn(startn), .stopn(stopn), .clearn(clearn),
    .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .zero(zero), .mag_on(mag_on), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mi, te, on;
    logic       z, m, d;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0, cyc_no = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 done
  int m_mode, m_min, m_rest;
  bit m_ldq, m_tq;

  function automatic void model_reset();
    m_mode = 0; m_min = 0; m_rest = 0; m_ldq = 1'b1; m_tq = 1'b0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.mi = 4'(m_min);
    e.te = 4'(m_rest / 10);
    e.on = 4'(m_rest % 10);
    e.z  = (m_min == 0) && (m_rest == 0);
    e.m  = (m_mode == 1);
    e.d  = (m_mode == 3);
    return e;
  endfunction

  function automatic void model_step();
    bit ld_ev, tk_ev;
    ld_ev = m_ldq && !loadn;
    tk_ev = pgt_1Hz && !m_tq;
    m_ldq = loadn;
    m_tq  = pgt_1Hz;
    if (!clearn) begin
      m_mode = 0; m_min = 0; m_rest = 0;
    end else begin
      case (m_mode)
        0: if (!startn) begin
             if (m_min != 0 || m_rest != 0) m_mode = 1;
           end else if (ld_ev && D <= 9) begin
             m_min  = m_rest / 10;
             m_rest = (m_rest % 10) * 10 + int'(D);
           end
        1: if (!stopn) m_mode = 2;
           else if (tk_ev) begin
             if (m_rest > 0) m_rest = m_rest - 1;
             else begin m_min = m_min - 1; m_rest = 5 * 10 + 9; end
             if (m_min == 0 && m_rest == 0) m_mode = 3;
           end
        2: if (stopn && !startn) m_mode = 1;
        default: ;
      endcase
    end
  endfunction

  function automatic void check(string name, exp_t got, exp_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle=%0d got %0d:%0d%0d z=%0b mag=%0b done=%0b want %0d:%0d%0d z=%0b mag=%0b done=%0b",
                  name, cyc_no, got.mi, got.te, got.on, got.z, got.m, got.d,
                  want.mi, want.te, want.on, want.z, want.m, want.d);
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e = '{mins, sec_tens, sec_ones, zero, mag_on, done};
    return e;
  endfunction

  // Monitor
  always @(posedge clk) begin
    cyc_no++;
    #1;
    if (q.size() != 0) check("scoreboard", dut_out(), q.pop_front());
  end

  // Driver primitives: inputs are already set; advance model, queue, wait.
  task automatic cyc();
    model_step();
    q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic key(input logic [3:0] d);
    D = d; loadn = 1'b0; cyc(); cyc();
    loadn = 1'b1; cyc();
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1; cyc(); cyc();
    pgt_1Hz = 1'b0; cyc(); cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start();
    startn = 1'b0; cyc();
    startn = 1'b1; cyc();
  endtask

  task automatic clear();
    clearn = 1'b0; cyc();
    clearn = 1'b1; cyc();
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired, got no finish want finish");
    $fatal(1);
  end

  initial begin
    exp_t rst_exp;
    model_reset();
    rst_exp = model_out();
    @(negedge clk);
    check("reset_state", dut_out(), rst_exp);
    rst = 1'b0;
    @(negedge clk);

    // Digit entry 1,3,0 -> 1:30 idle
    key(4'd1); key(4'd3); key(4'd0); idle(2);

    // 0:05 countdown to done, then extra ticks hold 0:00
    clear(); key(4'd0); key(4'd0); key(4'd5); start();
    ticks(5); ticks(20);

    // Minute borrow and linear seconds-tens above 5
    clear(); key(4'd1); key(4'd0); key(4'd0); start(); tick();
    clear(); key(4'd0); key(4'd9); key(4'd0); start(); tick(); ticks(10);

    // Pause: stop coincides with a tick edge, held across 3 ticks
    clear(); key(4'd0); key(4'd3); key(4'd0); start();
    stopn = 1'b0; tick(); tick(); tick();
    stopn = 1'b1; idle(1);
    start(); tick();

    // Invalid digit, start on 0:00, reach done, clear from done
    clear(); key(4'd12); start(); idle(1);
    key(4'd1); key(4'd12); start(); tick(); idle(1); clear();

    // Start and key strobe together: load dropped, start uses old digits
    key(4'd2); D = 4'd7; loadn = 1'b0; startn = 1'b0; cyc();
    startn = 1'b1; cyc(); loadn = 1'b1; cyc(); tick(); clear();

    // Async reset mid-run
    key(4'd0); key(4'd4); key(4'd5); start(); ticks(2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset", dut_out(), rst_exp);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    idle(1); tick(); idle(2);

    // Randomized panel activity
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: key(4'($urandom_range(0, 15)));
        4, 5:       start();
        6:          begin stopn = 1'b0; cyc(); cyc(); stopn = 1'b1; cyc(); end
        7, 8, 9:    ticks($urandom_range(1, 6));
        10:         if ($urandom_range(0, 3) == 0) clear(); else idle(1);
        default:    idle($urandom_range(1, 3));
      endcase
    end

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- Consumer end of the keypad/timer-input interface: accepts BCD digits strobed by `loadn` and the `pgt_1Hz` time base.
- Assembles a three-digit M:SS cook time by left-shift entry and counts it down once per second under start/stop/clear panel control.
- Drives the BCD display digits, the magnetron-enable and the done indication for the microwave controller.

Parameters:
- SEC_TENS_RELOAD, 5: value loaded into the seconds-tens digit on a borrow from minutes.
- MAX_DIGIT, 9: largest BCD digit accepted on D; larger values are ignored.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- D  input  4  BCD key digit, valid while loadn is low.
- loadn  input  1  active-low digit strobe; one digit is taken per falling edge.
- pgt_1Hz  input  1  1 Hz time base; one tick is taken per rising edge.
- startn  input  1  active-low start/resume, level-sampled.
- stopn  input  1  active-low pause, level-sampled.
- clearn  input  1  active-low clear, level-sampled.
- mins  output  4  BCD minutes digit.
- sec_tens  output  4  BCD seconds-tens digit.
- sec_ones  output  4  BCD seconds-ones digit.
- zero  output  1  high when mins, sec_tens and sec_ones are all 0.
- mag_on  output  1  magnetron enable, high only in RUN.
- done  output  1  high only in DONE.

Behaviour:
- Reset (rst=1, async): state=IDLE; mins=sec_tens=sec_ones=0; zero=1; mag_on=0; done=0; loadn_q=1; tick_q=0.
- Edge detect, all in the clk domain:
  - load_ev = loadn_q & ~loadn.
  - tick_ev = pgt_1Hz & ~tick_q.
  - loadn_q and tick_q update every clk.
  - Each event acts on the same clk edge that samples it; outputs change 1 clk after the input transition is sampled.
- States: IDLE, RUN, PAUSE, DONE. Priority per cycle: clearn > stopn > startn > tick_ev > load_ev.
- clearn=0 in any state: digits -> 0; state -> IDLE.
- IDLE:
  - load_ev with D<=MAX_DIGIT shifts: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. The old mins value is discarded.
  - load_ev with D>MAX_DIGIT: no change.
  - startn=0 with zero=0 -> RUN. startn=0 with zero=1 is ignored.
  - tick_ev is ignored.
- RUN:
  - tick_ev decrements M:SS. If sec_ones>0: sec_ones-1.
  - Else if sec_tens>0: sec_tens-1, sec_ones<=9.
  - Else (mins>0): mins-1, sec_tens<=SEC_TENS_RELOAD, sec_ones<=9.
  - A decrement that produces 0:00 moves to DONE on the same edge.
  - stopn=0 -> PAUSE. load_ev is ignored.
- PAUSE: digits held. startn=0 -> RUN. tick_ev and load_ev are ignored.
- DONE: digits stay 0:00. Only clearn leaves (-> IDLE). startn, load_ev and tick_ev are ignored.
- Entered seconds-tens values above 5 (e.g. "0 9 0") are legal and count down linearly: 0:90 -> 0:89 ... -> 0:00.
- mag_on, done and zero are registered and consistent with state and digits on the same cycle.
- Simultaneous tick_ev and stopn=0 in RUN: stop wins and no decrement occurs.
- Simultaneous load_ev and startn=0 in IDLE: start is evaluated on the pre-load digits, and the load is dropped.
- rst asserted mid-countdown: immediate return to the reset values, regardless of clk.

Test Plan:
- Reset, then loadn strobes with D=1, 3, 0 -> mins=1, sec_tens=3, sec_ones=0, zero=0, state IDLE, mag_on=0.
- Enter 0:05, startn pulse, 5 pgt_1Hz rising edges -> sec_ones counts 4, 3, 2, 1, 0. On the 5th tick, done=1, mag_on=0, zero=1. 20 extra ticks leave 0:00.
- Enter 1:00, start, 1 tick -> 0:59. Enter 0:90, start, 1 tick -> 0:89. Then 10 ticks -> 0:79.
- RUN at 0:30, stopn low for 3 ticks -> 0:30 held, mag_on=0. startn low -> mag_on=1, next tick -> 0:29.
- In IDLE, D=12 strobe -> digits unchanged. startn with 0:00 -> stays IDLE, mag_on=0. clearn in DONE -> IDLE, done=0.
- Assert rst asynchronously between clk edges mid-RUN -> all digits 0, mag_on=0, done=0 before the next clk edge. Deassert, then a tick edge produces no change.
